demux_1to8_buf: RTL and testbench

//   Buffered 1-to-8 demultiplexer: the counterpart of the team's 8:1 selector datapath.
//   - One valid/ready input stream carries an 8-bit word plus a 3-bit select.
//   - Each word is steered into one of eight output channels.
//   - Each channel has a one-entry holding register with its own valid/ready handshake.
//   - Sits between a single producer and eight independent consumers; counts accepted words.

---
 rtl/demux_1to8_buf_if.sv | 29 ++
 rtl/demux_1to8_buf.sv | 116 +++++++++++
 tb/tb_demux_1to8_buf.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/demux_1to8_buf_if.sv
// Handshake bundle for the buffered 1-to-8 demultiplexer: one producer stream in,
// eight per-channel valid/ready streams out, plus the accepted-word counter.
interface demux_1to8_buf_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEL_W = 3,
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned NUM_CH = 2 ** SEL_W;

    logic                    valid_i;
    logic                    ready_o;
    logic [SEL_W-1:0]        sel_i;
    logic [WIDTH-1:0]        data_i;
    logic [NUM_CH-1:0]       ch_valid_o;
    logic [NUM_CH-1:0]       ch_ready_i;
    logic [NUM_CH*WIDTH-1:0] ch_data_o;
    logic [CNT_W-1:0]        count_o;

    // Producer and consumers together form the environment side
    modport master (
        output valid_i, sel_i, data_i, ch_ready_i,
        input  ready_o, ch_valid_o, ch_data_o, count_o
    );

    modport slave (
        input  valid_i, sel_i, data_i, ch_ready_i,
        output ready_o, ch_valid_o, ch_data_o, count_o
    );
endinterface

// File: rtl/demux_1to8_buf.sv
// Buffered 1-to-8 demultiplexer: steers each accepted word into a one-entry holding
// register per channel, with same-cycle pop/refill bypass and an accepted-word counter.
module demux_1to8_buf #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEL_W = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    demux_1to8_buf_if.slave  bus
);
    localparam int unsigned NUM_CH = 2 ** SEL_W;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ch_state_t;

    ch_state_t               r_state     [NUM_CH];
    ch_state_t               w_state_nxt [NUM_CH];
    logic [WIDTH-1:0]        r_hold      [NUM_CH];
    logic [CNT_W-1:0]        r_count;

    logic [NUM_CH-1:0]       w_full;
    logic [NUM_CH-1:0]       w_pop;
    logic [NUM_CH-1:0]       w_wr;
    logic                    w_ready;
    logic                    w_acc;
    logic [NUM_CH*WIDTH-1:0] w_data_flat;

    // Target slot is free, or its consumer drains it this very cycle
    assign w_ready = ~w_full[bus.sel_i] | bus.ch_ready_i[bus.sel_i];
    assign w_acc   = bus.valid_i & w_ready;

    // Per-channel occupancy, pop and write strobes
    always_comb begin
        w_full = '0;
        w_pop  = '0;
        w_wr   = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_full[k] = (r_state[k] == ST_FULL);
            w_pop[k]  = w_full[k] & bus.ch_ready_i[k];
            w_wr[k]   = w_acc & (bus.sel_i == SEL_W'(k));
        end
    end

    // Channel EMPTY/FULL state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                r_state[k] <= ST_EMPTY;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                r_state[k] <= w_state_nxt[k];
            end
        end
    end

    // Channel next-state: a write always wins over a pop on the same channel
    always_comb begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_state_nxt[k] = r_state[k];
            case (r_state[k])
                ST_EMPTY: begin
                    if (w_wr[k]) begin
                        w_state_nxt[k] = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_pop[k] && !w_wr[k]) begin
                        w_state_nxt[k] = ST_EMPTY;
                    end
                end
                default: w_state_nxt[k] = ST_EMPTY;
            endcase
        end
    end

    // Holding registers keep their word until overwritten, so data is stable while stalled
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                r_hold[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (w_wr[k]) begin
                    r_hold[k] <= bus.data_i;
                end
            end
        end
    end

    // Accepted-word counter, wraps naturally at 2**CNT_W
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (w_acc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    always_comb begin
        w_data_flat = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_data_flat[k*WIDTH +: WIDTH] = r_hold[k];
        end
    end

    assign bus.ready_o    = w_ready;
    assign bus.ch_valid_o = w_full;
    assign bus.ch_data_o  = w_data_flat;
    assign bus.count_o    = r_count;

endmodule

// File: tb/tb_demux_1to8_buf.sv
// Randomized and directed bench for demux_1to8_buf against a slot-occupancy reference model;
// a second instance with a 4-bit counter shares the stimulus to exercise counter wrap.
module tb_demux_1to8_buf;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned NUM_CH = 8;

    logic clk;
    logic rst_n;

    demux_1to8_buf_if #(.WIDTH(WIDTH), .SEL_W(SEL_W), .CNT_W(16)) bus   ();
    demux_1to8_buf_if #(.WIDTH(WIDTH), .SEL_W(SEL_W), .CNT_W(4))  bus4  ();

    demux_1to8_buf #(.WIDTH(WIDTH), .SEL_W(SEL_W), .CNT_W(16)) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    demux_1to8_buf #(.WIDTH(WIDTH), .SEL_W(SEL_W), .CNT_W(4)) u_dut4 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus4.slave)
    );

    assign bus4.valid_i    = bus.valid_i;
    assign bus4.sel_i      = bus.sel_i;
    assign bus4.data_i     = bus.data_i;
    assign bus4.ch_ready_i = bus.ch_ready_i;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: which slots hold a word, what word, and how many were taken
    bit         m_full [NUM_CH];
    logic [7:0] m_hold [NUM_CH];
    int         m_count;

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NUM_CH; k++) begin
            m_full[k] = 1'b0;
            m_hold[k] = 8'h00;
        end
        m_count = 0;
    endtask

    function automatic bit model_ready(input int s, input logic [7:0] crdy);
        return !m_full[s] || crdy[s];
    endfunction

    task automatic check_outputs();
        logic [7:0]  exp_v;
        logic [63:0] exp_d;
        exp_v = '0;
        exp_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            exp_v[k] = m_full[k];
            exp_d[k*8 +: 8] = m_hold[k];
        end
        check("ch_valid", 64'(bus.ch_valid_o), 64'(exp_v));
        check("ch_data",  bus.ch_data_o, exp_d);
        check("count16",  64'(bus.count_o),  64'(m_count % 65536));
        check("count4",   64'(bus4.count_o), 64'(m_count % 16));
    endtask

    // One clock with the currently driven inputs; returns whether the word was accepted
    task automatic cycle(output bit acc);
        int         s;
        bit         exp_rdy;
        logic [7:0] crdy;
        logic [7:0] d;
        #1;
        s       = int'(bus.sel_i);
        crdy    = bus.ch_ready_i;
        d       = bus.data_i;
        exp_rdy = model_ready(s, crdy);
        check("ready", 64'(bus.ready_o), 64'(exp_rdy));
        acc = bus.valid_i && exp_rdy;
        @(posedge clk);
        #1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (m_full[k] && crdy[k]) m_full[k] = 1'b0;
        end
        if (acc) begin
            m_full[s] = 1'b1;
            m_hold[s] = d;
            m_count++;
        end
        check_outputs();
    endtask

    task automatic drive(input bit v, input int s, input logic [7:0] d, input logic [7:0] crdy);
        bus.valid_i    = v;
        bus.sel_i      = SEL_W'(s);
        bus.data_i     = d;
        bus.ch_ready_i = crdy;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_clear();
        check("rst_valid", 64'(bus.ch_valid_o), 64'h0);
        check("rst_data",  bus.ch_data_o, 64'h0);
        check("rst_count", 64'(bus.count_o), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    bit acc;
    bit pend;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_clear();
        drive(1'b0, 0, 8'h00, 8'h00);
        rst_n = 1'b0;
        #12;
        check("init_valid", 64'(bus.ch_valid_o), 64'h0);
        check("init_count", 64'(bus.count_o), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic routing
        drive(1'b1, 3, 8'hA5, 8'h00);
        cycle(acc);
        check("route_valid", 64'(bus.ch_valid_o), 64'h08);
        check("route_data3", 64'(bus.ch_data_o[3*8 +: 8]), 64'hA5);
        check("route_count", 64'(bus.count_o), 64'd1);

        // Backpressure on channel 6, then redirect to channel 1
        drive(1'b1, 6, 8'h66, 8'h00);
        cycle(acc);
        drive(1'b1, 6, 8'h77, 8'h00);
        #1;
        check("bp_ready0", 64'(bus.ready_o), 64'h0);
        cycle(acc);
        check("bp_hold6", 64'(bus.ch_data_o[6*8 +: 8]), 64'h66);
        drive(1'b1, 1, 8'h31, 8'h00);
        #1;
        check("bp_ready1", 64'(bus.ready_o), 64'h1);
        cycle(acc);
        check("bp_data1", 64'(bus.ch_data_o[1*8 +: 8]), 64'h31);

        // Bypass: full channel 0 popped and refilled in one cycle
        drive(1'b1, 0, 8'h11, 8'h00);
        cycle(acc);
        drive(1'b1, 0, 8'h22, 8'h01);
        #1;
        check("byp_ready", 64'(bus.ready_o), 64'h1);
        cycle(acc);
        check("byp_valid0", 64'(bus.ch_valid_o[0]), 64'h1);
        check("byp_data0", 64'(bus.ch_data_o[7:0]), 64'h22);

        // Reset mid-stream with channels 2 and 5 loaded
        drive(1'b1, 2, 8'h2C, 8'h00);
        cycle(acc);
        drive(1'b1, 5, 8'h5C, 8'h00);
        cycle(acc);
        drive(1'b0, 0, 8'h00, 8'h00);
        #2;
        do_reset();
        drive(1'b1, 5, 8'h00, 8'h00);
        #1;
        check("rst_ready", 64'(bus.ready_o), 64'h1);
        drive(1'b0, 0, 8'h00, 8'h00);

        // Streaming: eight words back-to-back, all consumers ready
        for (int k = 0; k < NUM_CH; k++) begin
            drive(1'b1, k, 8'(8'h10 + k), 8'hFF);
            cycle(acc);
            check("stream_acc", 64'(acc), 64'h1);
        end
        for (int k = 0; k < NUM_CH; k++) begin
            check("stream_slice", 64'(bus.ch_data_o[k*8 +: 8]), 64'(8'h10 + k));
        end
        check("stream_count", 64'(bus.count_o), 64'd8);

        // Counter wrap on the 4-bit instance
        drive(1'b0, 0, 8'h00, 8'h00);
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            drive(1'b1, int'($urandom_range(0, 7)), 8'($urandom), 8'hFF);
            cycle(acc);
            if (i == 15) check("wrap15", 64'(bus4.count_o), 64'd15);
            if (i == 16) check("wrap16", 64'(bus4.count_o), 64'd0);
            if (i == 17) check("wrap17", 64'(bus4.count_o), 64'd1);
        end

        // Random traffic; a stalled producer holds its word until taken
        pend = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!pend) begin
                drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                      8'($urandom), 8'($urandom));
            end else begin
                bus.ch_ready_i = 8'($urandom);
            end
            cycle(acc);
            pend = bus.valid_i && !acc;
            if (i == 1500) begin
                drive(1'b0, 0, 8'h00, 8'h00);
                do_reset();
                pend = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
